// File: rtl/apb_master.sv
// APB requester: turns valid/ready commands into APB SETUP/ACCESS transfers.
// Optional access timeout is enabled with `define APB_MASTER_TIMEOUT_EN.
module apb_master #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic              i_cmd_write,
    input  logic [ADDR_W-1:0] i_cmd_addr,
    input  logic [DATA_W-1:0] i_cmd_wdata,
    output logic              o_rsp_valid,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_rsp_err,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PWRITE,
    output logic [DATA_W-1:0] PWDATA,
    output logic              PSELx,
    output logic              PENABLE,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t state_reg, state_next;

    logic [ADDR_W-1:0] paddr_next;
    logic              pwrite_next;
    logic [DATA_W-1:0] pwdata_next;
    logic              psel_next;
    logic              penable_next;
    logic              rsp_valid_next;
    logic              rsp_err_next;
    logic [DATA_W-1:0] rsp_rdata_next;

    generate
        if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
            $error("apb_master: TIMEOUT_CYCLES must be >= 1");
        end
    endgenerate

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
`endif

    assign o_cmd_ready = (state_reg == IDLE);

    always_comb begin
        state_next     = state_reg;
        paddr_next     = PADDR;
        pwrite_next    = PWRITE;
        pwdata_next    = PWDATA;
        psel_next      = PSELx;
        penable_next   = PENABLE;
        rsp_valid_next = 1'b0;
        rsp_err_next   = o_rsp_err;
        rsp_rdata_next = o_rsp_rdata;
`ifdef APB_MASTER_TIMEOUT_EN
        wait_cnt_next  = wait_cnt_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (i_cmd_valid) begin
                    state_next   = SETUP;
                    paddr_next   = i_cmd_addr;
                    pwrite_next  = i_cmd_write;
                    pwdata_next  = i_cmd_wdata;
                    psel_next    = 1'b1;
                    penable_next = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
                    wait_cnt_next = '0;
`endif
                end
            end
            SETUP: begin
                state_next   = ACCESS;
                penable_next = 1'b1;
            end
            ACCESS: begin
                // PREADY wins over a timeout that expires in the same cycle
                if (PREADY) begin
                    state_next     = IDLE;
                    psel_next      = 1'b0;
                    penable_next   = 1'b0;
                    rsp_valid_next = 1'b1;
                    rsp_err_next   = PSLVERR;
                    if (!PWRITE) begin
                        rsp_rdata_next = PRDATA;
                    end
                end
`ifdef APB_MASTER_TIMEOUT_EN
                else if (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_next     = IDLE;
                    psel_next      = 1'b0;
                    penable_next   = 1'b0;
                    rsp_valid_next = 1'b1;
                    rsp_err_next   = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt_reg + CNT_W'(1);
                end
`endif
            end
            default: begin
                state_next   = IDLE;
                psel_next    = 1'b0;
                penable_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg   <= IDLE;
            PADDR       <= '0;
            PWRITE      <= 1'b0;
            PWDATA      <= '0;
            PSELx       <= 1'b0;
            PENABLE     <= 1'b0;
            o_rsp_valid <= 1'b0;
            o_rsp_err   <= 1'b0;
            o_rsp_rdata <= '0;
        end else begin
            state_reg   <= state_next;
            PADDR       <= paddr_next;
            PWRITE      <= pwrite_next;
            PWDATA      <= pwdata_next;
            PSELx       <= psel_next;
            PENABLE     <= penable_next;
            o_rsp_valid <= rsp_valid_next;
            o_rsp_err   <= rsp_err_next;
            o_rsp_rdata <= rsp_rdata_next;
        end
    end

`ifdef APB_MASTER_TIMEOUT_EN
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wait_cnt_reg <= '0;
        end else begin
            wait_cnt_reg <= wait_cnt_next;
        end
    end
`endif

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: cycle-exact APB sequencing plus a response scoreboard.
module tb_apb_master;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic        psel;
    logic        penable;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
        .i_clk       (clk),
        .i_reset_n   (reset_n),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_cmd_write (cmd_write),
        .i_cmd_addr  (cmd_addr),
        .i_cmd_wdata (cmd_wdata),
        .o_rsp_valid (rsp_valid),
        .o_rsp_rdata (rsp_rdata),
        .o_rsp_err   (rsp_err),
        .PADDR       (paddr),
        .PWRITE      (pwrite),
        .PWDATA      (pwdata),
        .PSELx       (psel),
        .PENABLE     (penable),
        .PRDATA      (prdata),
        .PREADY      (pready),
        .PSLVERR     (pslverr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    rsp_t        sb_q[$];
    logic [31:0] model_rdata = '0;
    int          vectors     = 0;
    int          miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pops the oldest expected response and compares it with the DUT outputs.
    task automatic check_rsp(input string tag);
        rsp_t e;
        chk({tag, "_rsp_valid"}, rsp_valid, 1'b1);
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_underflow"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_rsp_err"}, rsp_err, e.err);
            chk({tag, "_rsp_rdata"}, rsp_rdata, e.rdata);
        end
    endtask

    // Issues one command and plays the completer; returns in the response cycle.
    task automatic apb_xfer(input string tag, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input int waits,
                            input logic [31:0] rdata, input logic slverr);
        rsp_t e;
        chk({tag, "_cmd_ready"}, cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        step();
        e.err   = slverr;
        e.rdata = wr ? model_rdata : rdata;
        model_rdata = e.rdata;
        sb_q.push_back(e);
        // SETUP: present a conflicting command that must be ignored
        cmd_addr  = ~addr;
        cmd_write = ~wr;
        chk({tag, "_setup_psel"}, psel, 1'b1);
        chk({tag, "_setup_penable"}, penable, 1'b0);
        chk({tag, "_setup_ready"}, cmd_ready, 1'b0);
        chk({tag, "_setup_paddr"}, paddr, addr);
        chk({tag, "_setup_pwrite"}, pwrite, wr);
        chk({tag, "_setup_rsp_valid"}, rsp_valid, 1'b0);
        if (wr) chk({tag, "_setup_pwdata"}, pwdata, wdata);
        step();
        for (int i = 0; i <= waits; i++) begin
            cmd_valid = (i == 0);
            chk($sformatf("%s_acc%0d_penable", tag, i), penable, 1'b1);
            chk($sformatf("%s_acc%0d_psel", tag, i), psel, 1'b1);
            chk($sformatf("%s_acc%0d_paddr", tag, i), paddr, addr);
            chk($sformatf("%s_acc%0d_pwrite", tag, i), pwrite, wr);
            chk($sformatf("%s_acc%0d_rsp_valid", tag, i), rsp_valid, 1'b0);
            if (wr) chk($sformatf("%s_acc%0d_pwdata", tag, i), pwdata, wdata);
            if (i == waits) begin
                pready = 1'b1; prdata = rdata; pslverr = slverr;
            end else begin
                pready = 1'b0; prdata = ~rdata; pslverr = 1'b1;
            end
            step();
        end
        cmd_valid = 1'b0;
        pready    = 1'b0;
        prdata    = 32'h0BAD_F00D;
        pslverr   = 1'b1;
        check_rsp(tag);
        chk({tag, "_done_psel"}, psel, 1'b0);
        chk({tag, "_done_penable"}, penable, 1'b0);
        chk({tag, "_done_paddr_held"}, paddr, addr);
        $display("xfer %s: %s addr=%h wdata=%h waits=%0d rdata=%h err=%0d", tag,
                 wr ? "WR" : "RD", addr, wdata, waits, rsp_rdata, rsp_err);
    endtask

    initial begin
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        #12;
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_psel", psel, 1'b0);
        chk("rst_penable", penable, 1'b0);
        chk("rst_paddr", paddr, 32'h0);
        chk("rst_pwdata", pwdata, 32'h0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        step();

        apb_xfer("t1_wr", 1'b1, 32'h10, 32'hDEAD_BEEF, 0, 32'h1111_2222, 1'b0);
        step();
        chk("t1_no_queued_cmd", psel, 1'b0);
        chk("t1_rsp_once", rsp_valid, 1'b0);
        step();

        apb_xfer("t2_rd", 1'b0, 32'h10, 32'h0, 0, 32'hDEAD_BEEF, 1'b0);
        step();
        apb_xfer("t3_wr_wait", 1'b1, 32'h20, 32'hCAFE_BABE, 4, 32'h3333_4444, 1'b0);
        step();
        apb_xfer("t4_err", 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 0, 32'h0, 1'b1);
        // accepted in the response cycle of the previous transfer
        apb_xfer("t4_b2b_rd", 1'b0, 32'h44, 32'h0, 2, 32'hA5A5_5A5A, 1'b0);
        apb_xfer("rd_err_wait", 1'b0, 32'h08, 32'h0, 1, 32'h7777_8888, 1'b1);
        step();

`ifdef APB_MASTER_TIMEOUT_EN
        begin
            rsp_t e;
            cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h30; cmd_wdata = 32'h5555_AAAA;
            step();
            cmd_valid = 1'b0;
            e.err = 1'b1; e.rdata = model_rdata;
            sb_q.push_back(e);
            pready = 1'b0; pslverr = 1'b0;
            step();
            for (int i = 0; i < 16; i++) begin
                chk($sformatf("t6_acc%0d_rsp_valid", i), rsp_valid, 1'b0);
                chk($sformatf("t6_acc%0d_psel", i), psel, 1'b1);
                step();
            end
            check_rsp("t6_timeout");
            chk("t6_psel", psel, 1'b0);
            chk("t6_penable", penable, 1'b0);
            $display("xfer t6_timeout: WR addr=00000030 stuck PREADY err=%0d", rsp_err);
            step();
        end
`else
        apb_xfer("t6_long_wait", 1'b1, 32'h30, 32'h5555_AAAA, 20, 32'h0, 1'b0);
        step();
`endif

        // T5: reset during an ACCESS wait state
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h40; cmd_wdata = 32'h9999_0000;
        step();
        cmd_valid = 1'b0;
        pready = 1'b0; pslverr = 1'b0;
        step();
        step();
        chk("t5_in_wait", penable, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t5_async_psel", psel, 1'b0);
        chk("t5_async_penable", penable, 1'b0);
        chk("t5_async_paddr", paddr, 32'h0);
        chk("t5_async_rsp_valid", rsp_valid, 1'b0);
        model_rdata = '0;
        step();
        @(negedge clk);
        reset_n = 1'b1;
        step();
        chk("t5_ready_after", cmd_ready, 1'b1);
        chk("t5_no_rsp", rsp_valid, 1'b0);
        chk("t5_rdata_cleared", rsp_rdata, 32'h0);
        $display("xfer t5_reset: aborted WR addr=00000040, ready=%0d", cmd_ready);
        step();

        apb_xfer("t5_post_rd", 1'b0, 32'h48, 32'h0, 1, 32'hFEED_0001, 1'b0);
        step();
        chk("sb_empty", sb_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
